// File: rtl/frame_sender_pkg.sv
// frame_sender_pkg: shared types and sizing helpers for the serial frame transmitter.
//   state_e      - transmitter FSM states
//   level_width  - bits needed for a FIFO occupancy count of 0..depth
//   cnt_width    - bits for the shared shift/gap counter
//   frame_len    - cycles from one start bit to the next in back-to-back traffic
package frame_sender_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned data_w, input int unsigned gap);
    return $clog2(data_w + gap + 1);
  endfunction

  function automatic int unsigned frame_len(input int unsigned data_w, input int unsigned gap);
    return 1 + data_w + gap;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
//   clk, rst     - clock, synchronous active-high reset (pointers only)
//   push, wdata  - write a word; ignored while full
//   pop          - discard head; ignored while empty
//   rdata        - current head, valid whenever !empty
//   full, empty  - occupancy flags
//   level        - number of words stored
module sync_fifo
  import frame_sender_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic                            pop,
  input  logic [Width-1:0]                wdata,
  output logic [Width-1:0]                rdata,
  output logic                            full,
  output logic                            empty,
  output logic [level_width(Depth)-1:0]   level
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AddrW + 1)'(Depth));
  assign empty   = (level == '0);
  assign rdata   = mem_q[rd_ptr_q[AddrW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AddrW-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (AddrW + 1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  // Storage needs no reset: entries are only read once the pointers mark them valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/frame_sender.sv
// frame_sender: queues DATA_W-bit words and sends each as a serial frame:
// start bit (1), data MSB first, then at least GAP idle cycles at 0.
//   clk, rst              - clock, synchronous active-high reset
//   in_data/in_valid      - word offered; accepted when in_ready
//   in_ready              - FIFO not full
//   loss_clear            - clears data_loss (a same-cycle drop wins)
//   sout                  - serial line, idle 0
//   busy                  - start, data or gap cycle in progress
//   fifo_level            - words waiting, excluding the frame on the wire
//   data_loss             - sticky: a word was offered while full
module frame_sender
  import frame_sender_pkg::*;
#(
  parameter int unsigned DATA_W = 40,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned GAP    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            loss_clear,
  output logic                            sout,
  output logic                            busy,
  output logic [level_width(DEPTH)-1:0]   fifo_level,
  output logic                            data_loss
);

  localparam int unsigned CntW = cnt_width(DATA_W, GAP);
  localparam logic [CntW-1:0] LastShift = CntW'(DATA_W);
  localparam logic [CntW-1:0] LastGap   = CntW'(GAP - 1);

  state_e            state_q, state_d;
  logic [DATA_W:0]   shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              loss_q, loss_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && !fifo_full;
  assign data_loss = loss_q;

  sync_fifo #(
    .Width (DATA_W),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    sout     = 1'b0;
    busy     = 1'b1;
    case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = {1'b1, fifo_rdata};
          cnt_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        sout    = shift_q[DATA_W];
        shift_d = {shift_q[DATA_W-1:0], 1'b0};
        if (cnt_q == LastShift) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == LastGap) begin
          // Chain straight into the next frame so back-to-back spacing is exact.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = {1'b1, fifo_rdata};
            cnt_d    = '0;
            state_d  = StShift;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    loss_d = loss_q;
    if (loss_clear) loss_d = 1'b0;
    if (in_valid && !in_ready) loss_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      loss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      loss_q  <= loss_d;
    end
  end

endmodule

// File: tb/tb_frame_sender.sv
// tb_frame_sender: bench for frame_sender using three instances:
//   A: defaults (40-bit, depth 2, gap 1) with a scoreboard-driven frame receiver
//   B: depth 4 for back-to-back framing
//   C: 8-bit, gap 3 for the parameter sweep
module tb_frame_sender;

  localparam int unsigned AW = 40;
  localparam int unsigned AG = 1;
  localparam int unsigned CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [AW-1:0] a_data;
  logic          a_valid, a_clr, a_ready, a_sout, a_busy, a_loss;
  logic [1:0]    a_level;

  logic [AW-1:0] b_data;
  logic          b_valid, b_ready, b_sout, b_busy, b_loss;
  logic [2:0]    b_level;

  logic [CW-1:0] c_data;
  logic          c_valid, c_ready, c_sout, c_busy, c_loss;
  logic [1:0]    c_level;

  frame_sender #(.DATA_W(AW), .DEPTH(2), .GAP(AG)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .loss_clear(a_clr), .sout(a_sout), .busy(a_busy), .fifo_level(a_level),
    .data_loss(a_loss)
  );

  frame_sender #(.DATA_W(AW), .DEPTH(4), .GAP(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .loss_clear(1'b0), .sout(b_sout), .busy(b_busy), .fifo_level(b_level),
    .data_loss(b_loss)
  );

  frame_sender #(.DATA_W(CW), .DEPTH(2), .GAP(3)) dut_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .loss_clear(1'b0), .sout(c_sout), .busy(c_busy), .fifo_level(c_level),
    .data_loss(c_loss)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard for instance A: words pushed when accepted, popped per received frame.
  logic [AW-1:0] exp_q[$];
  bit            rx_active = 1'b0;
  int            rx_cnt = 0;
  logic [AW-1:0] rx_word;
  bit            gap_bad;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
      exp_q.delete();
    end else if (!rx_active) begin
      if (a_sout) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_word   = '0;
        gap_bad   = 1'b0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt <= AW) rx_word = {rx_word[AW-2:0], a_sout};
      else if (a_sout) gap_bad = 1'b1;
      if (rx_cnt == AW) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_frame: got %0h expected no frame", rx_word);
        end else begin
          check("sb_frame", rx_word, exp_q.pop_front());
        end
      end
      if (rx_cnt == AW + AG) begin
        check("sb_gap_zero", gap_bad, 0);
        rx_active = 1'b0;
      end
    end
  end

  typedef struct {
    logic          valid;
    logic          clr;
    logic [AW-1:0] data;
    logic          ready;
    logic [1:0]    level;
    logic          busy;
    logic          loss;
  } vec_t;

  vec_t vt[9];

  logic [AW-1:0] wb[3];
  logic [41:0]   bf[3];
  logic [23:0]   cbits;
  logic [41:0]   act42;
  logic [41:0]   busy42;
  logic [AW-1:0] w1;
  bit            model_rdy;
  int            n;
  int            peak;
  bit            saw_one;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_valid = 0; a_clr = 0; a_data = '0;
    b_valid = 0; b_data = '0;
    c_valid = 0; c_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", a_sout, 0);
    check("rst_busy", a_busy, 0);
    check("rst_level", a_level, 0);
    check("rst_loss", a_loss, 0);
    check("rst_ready", a_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single word at defaults.
    w1 = 40'hD999999991;
    a_valid = 1; a_data = w1; exp_q.push_back(w1);
    @(posedge clk); #1;
    a_valid = 0;
    check("t1_level_after_push", a_level, 1);
    check("t1_busy_before_start", a_busy, 0);
    act42 = '0; busy42 = '0;
    for (int k = 0; k < 42; k++) begin
      @(posedge clk); #1;
      act42  = {act42[40:0], a_sout};
      busy42 = {busy42[40:0], a_busy};
      if (a_loss) check("t1_loss", a_loss, 0);
    end
    check("t1_frame_bits", act42, {1'b1, w1, 1'b0});
    check("t1_busy_42", busy42, {42{1'b1}});
    @(posedge clk); #1;
    check("t1_busy_fall", a_busy, 0);
    check("t1_loss_end", a_loss, 0);

    // Overflow and loss-clear table on A.
    vt[0] = '{1, 0, 40'h11_2233_4455, 1, 1, 0, 0};
    vt[1] = '{1, 0, 40'hA5_5AA5_5A01, 1, 1, 1, 0};
    vt[2] = '{1, 0, 40'h80_0000_0001, 0, 2, 1, 0};
    vt[3] = '{1, 0, 40'hFF_FFFF_FFFF, 0, 2, 1, 1};
    vt[4] = '{1, 0, 40'h12_3456_789A, 0, 2, 1, 1};
    vt[5] = '{0, 1, 40'h0,            0, 2, 1, 0};
    vt[6] = '{1, 1, 40'hDE_ADBE_EF00, 0, 2, 1, 1};
    vt[7] = '{0, 1, 40'h0,            0, 2, 1, 0};
    vt[8] = '{0, 0, 40'h0,            0, 2, 1, 0};
    model_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_valid = vt[i].valid;
      a_clr   = vt[i].clr;
      a_data  = vt[i].data;
      if (vt[i].valid && model_rdy) exp_q.push_back(vt[i].data);
      @(posedge clk); #1;
      check($sformatf("ovf%0d_ready", i), a_ready, vt[i].ready);
      check($sformatf("ovf%0d_level", i), a_level, vt[i].level);
      check($sformatf("ovf%0d_busy", i), a_busy, vt[i].busy);
      check($sformatf("ovf%0d_loss", i), a_loss, vt[i].loss);
      model_rdy = vt[i].ready;
    end
    a_valid = 0; a_clr = 0;
    n = 0;
    while ((a_busy || a_level != 0 || rx_active) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("ovf_drained", {a_busy, a_level, rx_active}, 0);
    check("ovf_sb_empty", exp_q.size(), 0);

    // Reset during data bit 20 with one word queued.
    a_valid = 1; a_data = 40'h5A_F0F0_1E2D; exp_q.push_back(a_data);
    @(posedge clk); #1;
    a_data = 40'h0F_EDCB_A987; exp_q.push_back(a_data);
    @(posedge clk); #1;
    a_valid = 0;
    check("rst_mid_level", a_level, 1);
    repeat (20) @(posedge clk);
    #1;
    check("rst_mid_bit20", a_sout, 1'(40'h5A_F0F0_1E2D >> 20));
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_sout", a_sout, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_level0", a_level, 0);
    check("rst_mid_ready", a_ready, 1);
    rst = 1'b0;
    saw_one = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (a_sout || a_busy) saw_one = 1'b1;
    end
    check("rst_mid_no_frame", saw_one, 0);

    // Back-to-back on B (depth 4).
    wb[0] = 40'hC3_0000_0003;
    wb[1] = 40'h81_2481_2481;
    wb[2] = 40'hFE_DCBA_9876;
    b_valid = 1; b_data = wb[0];
    @(posedge clk); #1;
    check("b2b_level_e1", b_level, 1);
    b_data = wb[1];
    @(posedge clk); #1;
    peak = 0;
    bf[0] = '0; bf[1] = '0; bf[2] = '0;
    for (int t = 0; t < 126; t++) begin
      bf[t / 42] = {bf[t / 42][40:0], b_sout};
      if (int'(b_level) > peak) peak = int'(b_level);
      if (t == 0)  check("b2b_level_t0", b_level, 1);
      if (t == 1)  check("b2b_level_t1", b_level, 2);
      if (t == 41) check("b2b_level_t41", b_level, 2);
      if (t == 42) check("b2b_level_t42", b_level, 1);
      if (t == 84) check("b2b_level_t84", b_level, 0);
      if (t == 0) b_data = wb[2];
      else b_valid = 0;
      @(posedge clk); #1;
    end
    for (int f = 0; f < 3; f++) check($sformatf("b2b_frame%0d", f), bf[f], {1'b1, wb[f], 1'b0});
    check("b2b_peak", peak, 2);
    check("b2b_busy_end", b_busy, 0);
    check("b2b_loss", b_loss, 0);

    // Parameter sweep on C (8-bit, gap 3).
    c_valid = 1; c_data = 8'hA5;
    @(posedge clk); #1;
    c_data = 8'h3C;
    @(posedge clk); #1;
    c_valid = 0;
    cbits = '0;
    for (int t = 0; t < 24; t++) begin
      cbits = {cbits[22:0], c_sout};
      if (!c_busy) check("sweep_busy", c_busy, 1);
      @(posedge clk); #1;
    end
    check("sweep_frame0", cbits[23:12], 12'b1_1010_0101_000);
    check("sweep_frame1", cbits[11:0], 12'b1_0011_1100_000);
    check("sweep_busy_end", c_busy, 0);
    check("sweep_level_end", c_level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_sender.md
# frame_sender

Parametrised serial frame transmitter: accepts DATA_W-bit words over a valid/ready handshake into a DEPTH-entry FIFO. Each word goes out on a single wire as a frame: one start bit (1), then the data MSB first, then a minimum idle gap of 0s. It is the next-generation transmit path on the link, replacing the fixed 40-bit single-buffer sender. Width, queue depth and inter-frame gap are configurable, and overflow is reported through a sticky, clearable loss flag.

## Interface
- DATA_W, 40, payload bits per frame (≥1)
- DEPTH, 2, FIFO entries; power of two, ≥2
- GAP, 1, minimum idle cycles (sout=0) after the last data bit of a frame; ≥1
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  DATA_W  word to transmit
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  FIFO can accept; equals !full
- loss_clear  in  1  clears data_loss
- sout  out  1  serial output; idle level 0
- busy  out  1  frame in progress (start, data or gap cycle)
- fifo_level  out  $clog2(DEPTH)+1  words queued, excluding the frame being shifted
- data_loss  out  1  sticky: a valid word was dropped

## Operation
- Reset values: sout=0, busy=0, fifo_level=0, data_loss=0, in_ready=1, FSM=IDLE.
- Accept: a word is pushed when in_valid && in_ready.
- Drop: in_valid && !in_ready drops the word and sets data_loss on the next edge. This supports legacy producers that ignore ready.
- data_loss stays set until loss_clear or rst. If loss_clear and a drop occur in the same cycle, data_loss is set (set wins).
- in_ready is !full only. There is no same-cycle bypass: a pop in cycle N does not raise in_ready until N+1.
- FSM states:
  - IDLE: sout=0, busy=0. If the FIFO is non-empty, pop the head into the shifter (DATA_W+1 bits, start bit prepended) and go to SHIFT.
  - SHIFT: sout = shifter MSB. Shift left one bit per cycle, zero-fill. After 1+DATA_W cycles go to GAP.
  - GAP: sout=0, busy=1, for GAP cycles. On the last GAP cycle: if the FIFO is non-empty, pop and load directly and go to SHIFT (no IDLE cycle); otherwise go to IDLE.
- Counter width: $clog2(DATA_W+GAP+1) bits. The counter resets to 0 on each load.
- Push and pop in the same cycle: fifo_level is unchanged. The FIFO is never full and empty simultaneously.
- Mid-operation rst: the frame is abandoned, sout=0 on the next cycle, and FIFO contents are discarded.

## Timing
- Word accepted at edge E into an empty FIFO with FSM in IDLE:
  - pop at edge E+1
  - start bit on sout during cycle E+1..E+2
  - data bit DATA_W-1-i during cycle E+2+i
- Latency from the accepting edge to the start bit: 1 cycle.
- Back-to-back frame period is exactly 1+DATA_W+GAP cycles (42 at defaults).
- busy rises with the start bit. It falls one cycle after the last GAP cycle when nothing is queued.
- fifo_level updates on the edge of the push or pop.

## Structure
- Package frame_sender_pkg:
  - state enum {IDLE, SHIFT, GAP}
  - localparam helpers: level width, counter width, FRAME_LEN = 1+DATA_W+GAP
- Sub-module sync_fifo, parameterised by width and depth:
  - ports clk, rst, push, pop, wdata, rdata, full, empty, level
  - registered storage with a first-word-fall-through head
- Top level holds the FSM, the shifter, the counter and the loss logic.

## Test plan
- Single word, defaults: push 40'hD99999999_1 at E. Expect start bit at E+1, then the 40 bits MSB first, then sout=0. busy is high for 42 cycles and data_loss stays 0.
- Back-to-back: push 3 words in consecutive cycles with DEPTH=4. Expect frames with periods of exactly 42 cycles, the second start bit 42 cycles after the first, and fifo_level peaking at 2 (sequence 1,2,2,1,0 as frames pop).
- Overflow: DEPTH=2, hold in_valid for 5 cycles while idle. Expect 3 words accepted (one popped) and data_loss set on the edge after the first drop. in_ready is 0 while full. The frames sent match the accepted words only.
- Loss clear: with data_loss=1, pulse loss_clear and expect 0 next cycle. Repeat with a drop in the same cycle and expect data_loss to stay 1.
- Parameter sweep: DATA_W=8, GAP=3, word 8'hA5. Expect sout sequence 1,1,0,1,0,0,1,0,1,0,0,0 and a next-frame period of 12.
- Reset mid-frame: assert rst during data bit 20 with 1 word queued. Next cycle expect sout=0, busy=0, fifo_level=0 and in_ready=1. No frame follows.
